tri_setup: RTL and testbench

//  Triangle setup stage directly downstream of the triangle-draw fetch stage.
//  - Accepts the three fetched 64-bit vertices of one triangle.
//  - Computes twice the signed area, three edge-function coefficient sets and a screen-clipped bounding box.
//  - Hands one setup record per triangle to the rasterizer over a valid/ready handshake.
//  - Degenerate and fully off-screen triangles are dropped and counted.

---
 rtl/tri_setup_pkg.sv | 42 ++++
 rtl/tri_edge_fn.sv | 25 ++
 rtl/tri_setup.sv | 236 +++++++++++++++++++++++
 tb/tb_tri_setup.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tri_setup_pkg.sv
// Shared definitions for the triangle setup stage: vertex field layout, datapath widths, FSM states.
// Build option BACKFACE_CULL_EN (see tri_setup.sv) selects culling vs. reordering of clockwise triangles.
package tri_setup_pkg;

   localparam int DW_VERTEX = 64;
   localparam int X_LSB     = 0;
   localparam int Y_LSB     = 16;
   localparam int COL_LSB   = 32;
   localparam int CRD_W     = 16;
   localparam int COL_W     = 16;

   localparam int AREA_W    = 35;
   localparam int EA_W      = 17;
   localparam int EC_W      = 33;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AREA = 3'd1,
      ST_E0   = 3'd2,
      ST_E1   = 3'd3,
      ST_E2   = 3'd4,
      ST_BBOX = 3'd5,
      ST_OUT  = 3'd6
   } tri_state_e;

   function automatic logic signed [CRD_W-1:0] min3(input logic signed [CRD_W-1:0] a,
                                                    input logic signed [CRD_W-1:0] b,
                                                    input logic signed [CRD_W-1:0] c);
      logic signed [CRD_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic signed [CRD_W-1:0] max3(input logic signed [CRD_W-1:0] a,
                                                    input logic signed [CRD_W-1:0] b,
                                                    input logic signed [CRD_W-1:0] c);
      logic signed [CRD_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage

// File: rtl/tri_edge_fn.sv
// Combinational edge-function coefficients for the edge va->vb: A=ya-yb, B=xb-xa, C=xa*yb-xb*ya.
module tri_edge_fn
   import tri_setup_pkg::*;
(
   input  logic signed [CRD_W-1:0] xa,
   input  logic signed [CRD_W-1:0] ya,
   input  logic signed [CRD_W-1:0] xb,
   input  logic signed [CRD_W-1:0] yb,
   output logic [EA_W-1:0]         a,
   output logic [EA_W-1:0]         b,
   output logic [EC_W-1:0]         c
);

   logic signed [2*CRD_W-1:0] p_ab;
   logic signed [2*CRD_W-1:0] p_ba;

   assign p_ab = xa * yb;
   assign p_ba = xb * ya;

   // One extra bit of sign extension keeps every difference exact.
   assign a = {ya[CRD_W-1], ya} - {yb[CRD_W-1], yb};
   assign b = {xb[CRD_W-1], xb} - {xa[CRD_W-1], xa};
   assign c = {p_ab[2*CRD_W-1], p_ab} - {p_ba[2*CRD_W-1], p_ba};

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: area, three edge functions and clipped bounding box per triangle, one record out.
// Define BACKFACE_CULL_EN to drop clockwise triangles; otherwise they are reordered to counter-clockwise.
module tri_setup
   import tri_setup_pkg::*;
#(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240
) (
   input  logic                   CLK,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW_VERTEX-1:0]   v0,
   input  logic [DW_VERTEX-1:0]   v1,
   input  logic [DW_VERTEX-1:0]   v2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AREA_W-1:0]      area2,
   output logic [3*EA_W-1:0]      edge_a,
   output logic [3*EA_W-1:0]      edge_b,
   output logic [3*EC_W-1:0]      edge_c,
   output logic [15:0]            bb_xmin,
   output logic [15:0]            bb_xmax,
   output logic [15:0]            bb_ymin,
   output logic [15:0]            bb_ymax,
   output logic [COL_W-1:0]       color,
   output logic                   BUSY,
   output logic [15:0]            drop_cnt,
   output logic [2:0]             dbg_state
);

   // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both high;
   // the producer holds valid and data stable until then, and ready never depends on valid.

   localparam logic signed [CRD_W-1:0] X_LIM = CRD_W'(SCREEN_W - 1);
   localparam logic signed [CRD_W-1:0] Y_LIM = CRD_W'(SCREEN_H - 1);

   tri_state_e state_q, state_d;

   logic signed [CRD_W-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
   logic [COL_W-1:0]        color_q;
   logic [AREA_W-1:0]       area_q;
   logic [3*EA_W-1:0]       ea_q, eb_q;
   logic [3*EC_W-1:0]       ec_q;
   logic [15:0]             bx0_q, bx1_q, by0_q, by1_q;
   logic                    out_valid_q, busy_q;
   logic [15:0]             drop_cnt_q;
   logic                    drop;

   logic unused_hi;
   assign unused_hi = ^{v0[DW_VERTEX-1:COL_LSB+COL_W], v1[DW_VERTEX-1:COL_LSB],
                        v2[DW_VERTEX-1:COL_LSB]};

   // Twice the signed area, exact at 35 bits.
   logic signed [CRD_W:0]     dx1, dy1, dx2, dy2;
   logic signed [2*CRD_W+1:0] prod_a, prod_b;
   logic [AREA_W-1:0]         area_c;
   logic                      neg_drop;

   assign dx1    = {x1_q[CRD_W-1], x1_q} - {x0_q[CRD_W-1], x0_q};
   assign dy1    = {y1_q[CRD_W-1], y1_q} - {y0_q[CRD_W-1], y0_q};
   assign dx2    = {x2_q[CRD_W-1], x2_q} - {x0_q[CRD_W-1], x0_q};
   assign dy2    = {y2_q[CRD_W-1], y2_q} - {y0_q[CRD_W-1], y0_q};
   assign prod_a = dx1 * dy2;
   assign prod_b = dx2 * dy1;
   assign area_c = {prod_a[2*CRD_W+1], prod_a} - {prod_b[2*CRD_W+1], prod_b};

`ifdef BACKFACE_CULL_EN
   assign neg_drop = area_c[AREA_W-1];
`else
   assign neg_drop = 1'b0;
`endif

   // Single edge evaluator shared across E0..E2.
   logic signed [CRD_W-1:0] xa, ya, xb, yb;
   logic [EA_W-1:0]         e_a, e_b;
   logic [EC_W-1:0]         e_c;

   always_comb begin
      xa = x1_q; ya = y1_q; xb = x2_q; yb = y2_q;
      case (state_q)
         ST_E1:   begin xa = x2_q; ya = y2_q; xb = x0_q; yb = y0_q; end
         ST_E2:   begin xa = x0_q; ya = y0_q; xb = x1_q; yb = y1_q; end
         default: ;
      endcase
   end

   tri_edge_fn u_edge (
      .xa (xa),
      .ya (ya),
      .xb (xb),
      .yb (yb),
      .a  (e_a),
      .b  (e_b),
      .c  (e_c)
   );

   logic signed [CRD_W-1:0] xmin, xmax, ymin, ymax;
   logic                    bb_off;

   assign xmin   = min3(x0_q, x1_q, x2_q);
   assign xmax   = max3(x0_q, x1_q, x2_q);
   assign ymin   = min3(y0_q, y1_q, y2_q);
   assign ymax   = max3(y0_q, y1_q, y2_q);
   assign bb_off = (xmax < 0) || (ymax < 0) || (xmin > X_LIM) || (ymin > Y_LIM);

   always_ff @(posedge CLK) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      drop    = 1'b0;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_AREA;
         ST_AREA: begin
            if (area_c == '0 || neg_drop) begin
               drop    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_E0;
            end
         end
         ST_E0:   state_d = ST_E1;
         ST_E1:   state_d = ST_E2;
         ST_E2:   state_d = ST_BBOX;
         ST_BBOX: begin
            if (bb_off) begin
               drop    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         ST_OUT:  if (out_valid_q && out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
         color_q     <= '0;
         area_q      <= '0;
         ea_q        <= '0;
         eb_q        <= '0;
         ec_q        <= '0;
         bx0_q       <= '0;
         bx1_q       <= '0;
         by0_q       <= '0;
         by1_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         if (drop) begin
            busy_q     <= 1'b0;
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  x0_q    <= v0[X_LSB +: CRD_W];
                  y0_q    <= v0[Y_LSB +: CRD_W];
                  x1_q    <= v1[X_LSB +: CRD_W];
                  y1_q    <= v1[Y_LSB +: CRD_W];
                  x2_q    <= v2[X_LSB +: CRD_W];
                  y2_q    <= v2[Y_LSB +: CRD_W];
                  color_q <= v0[COL_LSB +: COL_W];
                  busy_q  <= 1'b1;
               end
            end
            ST_AREA: begin
               // Clockwise triangles are flipped so edges and area come out counter-clockwise.
               if (area_c[AREA_W-1] && !neg_drop) begin
                  x1_q   <= x2_q; y1_q <= y2_q;
                  x2_q   <= x1_q; y2_q <= y1_q;
                  area_q <= -area_c;
               end else begin
                  area_q <= area_c;
               end
            end
            ST_E0: begin
               ea_q[0*EA_W +: EA_W] <= e_a;
               eb_q[0*EA_W +: EA_W] <= e_b;
               ec_q[0*EC_W +: EC_W] <= e_c;
            end
            ST_E1: begin
               ea_q[1*EA_W +: EA_W] <= e_a;
               eb_q[1*EA_W +: EA_W] <= e_b;
               ec_q[1*EC_W +: EC_W] <= e_c;
            end
            ST_E2: begin
               ea_q[2*EA_W +: EA_W] <= e_a;
               eb_q[2*EA_W +: EA_W] <= e_b;
               ec_q[2*EC_W +: EC_W] <= e_c;
            end
            ST_BBOX: begin
               if (!bb_off) begin
                  bx0_q <= (xmin < 0) ? 16'd0 : xmin;
                  by0_q <= (ymin < 0) ? 16'd0 : ymin;
                  bx1_q <= (xmax > X_LIM) ? X_LIM : xmax;
                  by1_q <= (ymax > Y_LIM) ? Y_LIM : ymax;
               end
            end
            ST_OUT: begin
               // First OUT cycle registers the record; valid rises on the following edge.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign area2     = area_q;
   assign edge_a    = ea_q;
   assign edge_b    = eb_q;
   assign edge_c    = ec_q;
   assign bb_xmin   = bx0_q;
   assign bb_xmax   = bx1_q;
   assign bb_ymin   = by0_q;
   assign bb_ymax   = by1_q;
   assign color     = color_q;
   assign BUSY      = busy_q;
   assign drop_cnt  = drop_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tri_setup.sv
// Directed bench for tri_setup: hand-computed records, drops, clipping, backpressure and mid-run reset.
module tb_tri_setup;

  logic         CLK = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  v0, v1, v2;
  logic         out_valid;
  logic         out_ready;
  logic [34:0]  area2;
  logic [50:0]  edge_a, edge_b;
  logic [98:0]  edge_c;
  logic [15:0]  bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic [15:0]  color;
  logic         BUSY;
  logic [15:0]  drop_cnt;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  tri_setup dut (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v0        (v0),
    .v1        (v1),
    .v2        (v2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .area2     (area2),
    .edge_a    (edge_a),
    .edge_b    (edge_b),
    .edge_c    (edge_c),
    .bb_xmin   (bb_xmin),
    .bb_xmax   (bb_xmax),
    .bb_ymin   (bb_ymin),
    .bb_ymax   (bb_ymax),
    .color     (color),
    .BUSY      (BUSY),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_v(input int x, input int y, input logic [15:0] c);
    logic [15:0] xs, ys;
    xs = 16'(x);
    ys = 16'(y);
    return {16'hDEAD, c, ys, xs};
  endfunction

  task automatic send_tri(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(negedge CLK);
    v0 = a; v1 = b; v2 = c;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Counts negedges after the accept until out_valid; 99 on timeout.
  task automatic wait_out(output int lat);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_rec(input string tag, input logic [34:0] a2,
                            input logic [50:0] ea, input logic [50:0] eb, input logic [98:0] ec,
                            input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1,
                            input logic [15:0] col);
    check({tag, ".area2"},  area2,   a2);
    check({tag, ".edge_a"}, edge_a,  ea);
    check({tag, ".edge_b"}, edge_b,  eb);
    check({tag, ".edge_c"}, edge_c,  ec);
    check({tag, ".xmin"},   bb_xmin, x0);
    check({tag, ".xmax"},   bb_xmax, x1);
    check({tag, ".ymin"},   bb_ymin, y0);
    check({tag, ".ymax"},   bb_ymax, y1);
    check({tag, ".color"},  color,   col);
  endtask

  task automatic expect_taken(input string tag);
    @(negedge CLK);
    check({tag, ".valid_low"}, out_valid, 1'b0);
    check({tag, ".busy_low"},  BUSY,      1'b0);
    check({tag, ".in_ready"},  in_ready,  1'b1);
  endtask

  // Expected edges for triangle (10,10),(50,10),(10,40) in counter-clockwise order.
  logic [50:0] t1_ea, t1_eb;
  logic [98:0] t1_ec;
  logic [50:0] t4_ea, t4_eb;
  logic [98:0] t4_ec;

  initial begin
    int lat;
    int n;
    bit seen;
    t1_ea = {17'(0),    17'(30),    17'(-30)};
    t1_eb = {17'(40),   17'(0),     17'(-40)};
    t1_ec = {33'(-400), 33'(-300),  33'(1900)};
    t4_ea = {17'(0),    17'(320),   17'(-320)};
    t4_eb = {17'(420),  17'(0),     17'(-420)};
    t4_ec = {33'(8400), 33'(6400),  33'(119600)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    v0 = '0; v1 = '0; v2 = '0;
    repeat (3) @(negedge CLK);
    check("rst.in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge CLK);
    check("rst.in_ready_after", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", BUSY, 1'b0);
    check("rst.drop_cnt", drop_cnt, 16'd0);
    check("rst.area2", area2, 35'd0);
    check("rst.state", dbg_state, 3'd0);

    // Test 1: basic counter-clockwise triangle.
    send_tri(mk_v(10, 10, 16'hF800), mk_v(50, 10, 16'h07E0), mk_v(10, 40, 16'h001F));
    check("t1.busy", BUSY, 1'b1);
    check("t1.in_ready", in_ready, 1'b0);
    wait_out(lat);
    check("t1.latency", 32'(lat), 32'd6);
    expect_rec("t1", 35'd1200, t1_ea, t1_eb, t1_ec, 16'd10, 16'd50, 16'd10, 16'd40, 16'hF800);
    expect_taken("t1");

    // Test 2: same triangle, clockwise order.
    send_tri(mk_v(10, 10, 16'h1234), mk_v(10, 40, 16'h07E0), mk_v(50, 10, 16'h001F));
`ifdef BACKFACE_CULL_EN
    exp_drop++;
    @(negedge CLK);
    check("t2.busy", BUSY, 1'b0);
    check("t2.out_valid", out_valid, 1'b0);
    check("t2.drop_cnt", drop_cnt, 16'(exp_drop));
`else
    wait_out(lat);
    check("t2.latency", 32'(lat), 32'd6);
    expect_rec("t2", 35'd1200, t1_ea, t1_eb, t1_ec, 16'd10, 16'd50, 16'd10, 16'd40, 16'h1234);
    check("t2.drop_cnt", drop_cnt, 16'(exp_drop));
    expect_taken("t2");
`endif

    // Test 3: collinear vertices, dropped in AREA.
    send_tri(mk_v(0, 0, 16'h0001), mk_v(10, 10, 16'h0002), mk_v(20, 20, 16'h0003));
    exp_drop++;
    @(negedge CLK);
    check("t3.busy", BUSY, 1'b0);
    check("t3.out_valid", out_valid, 1'b0);
    check("t3.drop_cnt", drop_cnt, 16'(exp_drop));
    check("t3.in_ready", in_ready, 1'b1);

    // Test 4a: partially off-screen, clamped to the full screen.
    send_tri(mk_v(-20, -20, 16'hABCD), mk_v(400, -20, 16'h0000), mk_v(-20, 300, 16'h0000));
    wait_out(lat);
    check("t4a.latency", 32'(lat), 32'd6);
    expect_rec("t4a", 35'd134400, t4_ea, t4_eb, t4_ec, 16'd0, 16'd319, 16'd0, 16'd239, 16'hABCD);
    expect_taken("t4a");

    // Test 4b: entirely right of the screen, dropped in BBOX.
    send_tri(mk_v(400, 0, 16'h0000), mk_v(500, 0, 16'h0000), mk_v(400, 50, 16'h0000));
    exp_drop++;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
      if (!BUSY) begin
        n = i;
        break;
      end
    end
    check("t4b.no_valid", seen, 1'b0);
    check("t4b.busy_clear_cycle", 32'(n), 32'd5);
    check("t4b.drop_cnt", drop_cnt, 16'(exp_drop));

    // Test 5: backpressure for five cycles after out_valid.
    out_ready = 1'b0;
    send_tri(mk_v(10, 10, 16'h5A5A), mk_v(50, 10, 16'h0000), mk_v(10, 40, 16'h0000));
    wait_out(lat);
    check("t5.latency", 32'(lat), 32'd6);
    for (int i = 0; i < 5; i++) begin
      check("t5.hold_valid", out_valid, 1'b1);
      check("t5.hold_in_ready", in_ready, 1'b0);
      check("t5.hold_busy", BUSY, 1'b1);
      expect_rec("t5.hold", 35'd1200, t1_ea, t1_eb, t1_ec, 16'd10, 16'd50, 16'd10, 16'd40, 16'h5A5A);
      @(negedge CLK);
    end
    check("t5.still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    expect_taken("t5");

    // Test 6: reset while in AREA.
    check("t6.drop_cnt_before", drop_cnt, 16'(exp_drop));
    send_tri(mk_v(10, 10, 16'h0000), mk_v(50, 10, 16'h0000), mk_v(10, 40, 16'h0000));
    check("t6.state_area", dbg_state, 3'd1);
    rst = 1'b1;
    exp_drop = 0;
    @(negedge CLK);
    check("t6.out_valid", out_valid, 1'b0);
    check("t6.busy", BUSY, 1'b0);
    check("t6.drop_cnt", drop_cnt, 16'(exp_drop));
    check("t6.in_ready_in_rst", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("t6.in_ready_after", in_ready, 1'b1);
    check("t6.state_idle", dbg_state, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
